// File: rtl/omsp_spm_cmd_sequencer.sv
// Sequences Sancus SM enable/disable/verify commands into the SM control array and
// streams the derived module key into a newly enabled SM. Option: SPM_KEY_TIMEOUT_EN.
module omsp_spm_cmd_sequencer #(
  parameter int unsigned KEY_WORDS    = 8,
  parameter int unsigned KEY_IDX_SIZE = 3
) (
  input  logic                      mclk,
  input  logic                      puc_rst_n,
  input  logic                      cmd_valid,
  input  logic [1:0]                cmd_op,
  output logic                      cmd_ready,
  input  logic                      key_valid,
  input  logic [KEY_WORDS*16-1:0]   key_data,
  output logic                      key_ready,
  input  logic                      violation,
  output logic                      update_spm,
  output logic                      enable_spm,
  output logic                      disable_spm,
  output logic                      verify_spm,
  output logic                      cancel_spm,
  output logic                      write_key,
  output logic [15:0]               key_in,
  output logic [KEY_IDX_SIZE-1:0]   key_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, CHECK, WAIT_KEY, LOAD, CANCEL, FIN
  } state_e;

  typedef enum logic [1:0] {
    OP_ENABLE  = 2'b00,
    OP_DISABLE = 2'b01,
    OP_VERIFY  = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = KEY_IDX_SIZE'(KEY_WORDS - 1);

  state_e                  state;
  op_e                     op_q;
  op_e                     cmd_op_e;
  logic [KEY_WORDS*16-1:0] key_q;
`ifdef SPM_KEY_TIMEOUT_EN
  logic [7:0]              tmo_cnt;
`endif

  assign cmd_op_e  = op_e'(cmd_op);
  assign cmd_ready = (state == IDLE);
  assign key_ready = (state == WAIT_KEY);
  assign busy      = (state != IDLE);

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state       <= IDLE;
      op_q        <= OP_ENABLE;
      key_q       <= '0;
      update_spm  <= 1'b0;
      enable_spm  <= 1'b0;
      disable_spm <= 1'b0;
      verify_spm  <= 1'b0;
      cancel_spm  <= 1'b0;
      write_key   <= 1'b0;
      key_in      <= '0;
      key_idx     <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef SPM_KEY_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      update_spm  <= 1'b0;
      enable_spm  <= 1'b0;
      disable_spm <= 1'b0;
      verify_spm  <= 1'b0;
      cancel_spm  <= 1'b0;
      write_key   <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op_e;
            if (cmd_op_e == OP_RSVD) begin
              error <= 1'b1;
            end else begin
              // Strobes are registered on accept so they coincide with ISSUE.
              state       <= ISSUE;
              update_spm  <= 1'b1;
              enable_spm  <= (cmd_op_e == OP_ENABLE);
              disable_spm <= (cmd_op_e == OP_DISABLE);
              verify_spm  <= (cmd_op_e == OP_VERIFY);
            end
          end
        end
        ISSUE: state <= CHECK;
        CHECK: begin
          if (op_q == OP_ENABLE) begin
            if (violation) begin
              state      <= CANCEL;
              update_spm <= 1'b1;
              cancel_spm <= 1'b1;
            end else begin
              state <= WAIT_KEY;
`ifdef SPM_KEY_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end
          end else begin
            state <= FIN;
            done  <= ~violation;
            error <= violation;
          end
        end
        WAIT_KEY: begin
`ifdef SPM_KEY_TIMEOUT_EN
          // Timeout takes priority over a key arriving in the same cycle.
          if (tmo_cnt == 8'd254) begin
            state      <= CANCEL;
            update_spm <= 1'b1;
            cancel_spm <= 1'b1;
          end else if (key_valid) begin
            state     <= LOAD;
            key_q     <= key_data >> 16;
            key_in    <= key_data[15:0];
            key_idx   <= '0;
            write_key <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`else
          if (key_valid) begin
            state     <= LOAD;
            key_q     <= key_data >> 16;
            key_in    <= key_data[15:0];
            key_idx   <= '0;
            write_key <= 1'b1;
          end
`endif
        end
        LOAD: begin
          if (key_idx == LAST_IDX) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            write_key <= 1'b1;
            key_idx   <= key_idx + KEY_IDX_SIZE'(1);
            key_in    <= key_q[15:0];
            key_q     <= key_q >> 16;
          end
        end
        CANCEL: begin
          state <= FIN;
          error <= 1'b1;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_omsp_spm_cmd_sequencer.sv
// Bench for omsp_spm_cmd_sequencer: command table driven through a cycle-stamped
// event scoreboard, plus a reset-during-key-load sequence. Honours SPM_KEY_TIMEOUT_EN.
module tb_omsp_spm_cmd_sequencer;

  localparam int KW  = 8;
  localparam int KIS = 3;

  logic              mclk = 1'b0;
  logic              puc_rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = '0;
  logic              cmd_ready;
  logic              key_valid = 1'b0;
  logic [KW*16-1:0]  key_data = '0;
  logic              key_ready;
  logic              violation = 1'b0;
  logic              update_spm, enable_spm, disable_spm, verify_spm, cancel_spm;
  logic              write_key;
  logic [15:0]       key_in;
  logic [KIS-1:0]    key_idx;
  logic              busy, done, error;

  omsp_spm_cmd_sequencer #(.KEY_WORDS(KW), .KEY_IDX_SIZE(KIS)) dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
    .violation(violation),
    .update_spm(update_spm), .enable_spm(enable_spm), .disable_spm(disable_spm),
    .verify_spm(verify_spm), .cancel_spm(cancel_spm),
    .write_key(write_key), .key_in(key_in), .key_idx(key_idx),
    .busy(busy), .done(done), .error(error)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  typedef struct packed {
    logic upd, en, dis, ver, can, wk;
    logic [15:0] kin;
    logic [KIS-1:0] kidx;
    logic done, err;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } ev_t;

  typedef struct {
    logic [1:0]       op;
    bit               viol;
    bit               send_key;
    int               kd;
    logic [KW*16-1:0] key;
    int               exp_fin;
    bit               exp_err;
  } vec_t;

  ev_t  exp_q[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [KW*16-1:0] rkey();
    logic [KW*16-1:0] r;
    for (int i = 0; i < KW; i++) r[i*16 +: 16] = 16'($urandom);
    return r;
  endfunction

  function automatic vec_t mkv(input logic [1:0] op, input bit viol, input bit sk,
                               input int kd, input logic [KW*16-1:0] key,
                               input int fin, input bit err);
    vec_t v;
    v.op = op; v.viol = viol; v.send_key = sk; v.kd = kd;
    v.key = key; v.exp_fin = fin; v.exp_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic push_ev(input int c, input obs_t o);
    ev_t e;
    e.cyc = c;
    e.o   = o;
    exp_q.push_back(e);
  endtask

  // Advance to the next falling edge and score any output activity seen there.
  task automatic tick();
    obs_t obs;
    ev_t  e;
    @(negedge mclk);
    if (puc_rst_n) begin
      obs      = '0;
      obs.upd  = update_spm;
      obs.en   = enable_spm;
      obs.dis  = disable_spm;
      obs.ver  = verify_spm;
      obs.can  = cancel_spm;
      obs.wk   = write_key;
      obs.kin  = write_key ? key_in : 16'h0;
      obs.kidx = write_key ? key_idx : '0;
      obs.done = done;
      obs.err  = error;
      if (obs != '0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event cycle=%0d actual=%h required=none", cyc, obs);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.o !== obs) begin
            n_fail++;
            $display("FAIL event cycle=%0d actual=%h required=%h@cycle%0d", cyc, obs, e.o, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_key_ready", key_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_error", {done, error}, 0);
    chk("rst_strobes", {update_spm, enable_spm, disable_spm, verify_spm, cancel_spm}, 0);
    chk("rst_write_key", write_key, 0);
    chk("rst_key_in", key_in, 0);
    chk("rst_key_idx", key_idx, 0);
  endtask

  // Called at a falling edge with the sequencer idle; returns at the first cycle
  // in which the next command may be accepted.
  task automatic run_cmd(input vec_t v);
    int   c0, rel, kr_end;
    bit   cancel_case, exp_busy, exp_kr;
    obs_t o;
    c0 = cyc;
    cancel_case = (v.op == 2'b00) && v.exp_err;
    kr_end = (v.send_key && v.kd < v.exp_fin - 2) ? v.kd : v.exp_fin - 2;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    violation = v.viol;
    if (v.op != 2'b11) begin
      o = '0; o.upd = 1'b1;
      o.en = (v.op == 2'b00); o.dis = (v.op == 2'b01); o.ver = (v.op == 2'b10);
      push_ev(c0 + 1, o);
    end
    if (v.op == 2'b00) begin
      if (cancel_case) begin
        o = '0; o.upd = 1'b1; o.can = 1'b1;
        push_ev(c0 + v.exp_fin - 1, o);
      end else begin
        for (int n = 0; n < KW; n++) begin
          o = '0; o.wk = 1'b1; o.kin = v.key[n*16 +: 16]; o.kidx = KIS'(n);
          push_ev(c0 + v.kd + 1 + n, o);
        end
      end
    end
    o = '0;
    if (v.exp_err) o.err = 1'b1; else o.done = 1'b1;
    push_ev(c0 + v.exp_fin, o);
    do begin
      tick();
      rel = cyc - c0;
      if (rel == 1) begin
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
      end
      exp_busy = (v.op != 2'b11) && rel >= 1 && rel <= v.exp_fin;
      exp_kr   = (v.op == 2'b00) && !v.viol && rel >= 3 && rel <= kr_end;
      chk("busy", busy, exp_busy);
      chk("cmd_ready", cmd_ready, !exp_busy);
      chk("key_ready", key_ready, exp_kr);
      if (v.send_key && rel == v.kd) begin
        key_valid = 1'b1;
        key_data  = v.key;
      end
      if (v.send_key && rel == v.kd + 1) begin
        key_valid = 1'b0;
        key_data  = rkey();
      end
    end while (rel <= v.exp_fin);
    violation = 1'b0;
    chk("events_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [KW*16-1:0] tp;
    logic [KW*16-1:0] rk;
    obs_t o;
    int   c0, rel;

    tp = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    tbl.push_back(mkv(2'b00, 0, 1, 5, tp, 14, 0));
    tbl.push_back(mkv(2'b00, 1, 0, 0, '0, 4, 1));
    tbl.push_back(mkv(2'b01, 0, 0, 0, '0, 3, 0));
    tbl.push_back(mkv(2'b10, 1, 0, 0, '0, 3, 1));
    tbl.push_back(mkv(2'b11, 0, 0, 0, '0, 1, 1));
    tbl.push_back(mkv(2'b10, 0, 0, 0, '0, 3, 0));
    tbl.push_back(mkv(2'b01, 1, 0, 0, '0, 3, 1));
    tbl.push_back(mkv(2'b00, 0, 1, 3, rkey(), 12, 0));
    tbl.push_back(mkv(2'b00, 0, 1, 7, rkey(), 16, 0));
`ifdef SPM_KEY_TIMEOUT_EN
    tbl.push_back(mkv(2'b00, 0, 0, 0, '0, 259, 1));
    tbl.push_back(mkv(2'b00, 0, 1, 257, rkey(), 259, 1));
    tbl.push_back(mkv(2'b00, 0, 1, 256, rkey(), 265, 0));
`else
    tbl.push_back(mkv(2'b00, 0, 1, 300, rkey(), 309, 0));
`endif

    repeat (3) tick();
    chk_reset_vals();
    puc_rst_n = 1'b1;
    tick();

    foreach (tbl[i]) run_cmd(tbl[i]);

    // Reset while word 3 of the key is being written.
    rk = rkey();
    c0 = cyc;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    o = '0; o.upd = 1'b1; o.en = 1'b1;
    push_ev(c0 + 1, o);
    for (int n = 0; n < KW; n++) begin
      o = '0; o.wk = 1'b1; o.kin = rk[n*16 +: 16]; o.kidx = KIS'(n);
      push_ev(c0 + 6 + n, o);
    end
    do begin
      tick();
      rel = cyc - c0;
      if (rel == 1) cmd_valid = 1'b0;
      if (rel == 5) begin key_valid = 1'b1; key_data = rk; end
      if (rel == 6) begin key_valid = 1'b0; key_data = rkey(); end
    end while (rel < 9);
    chk("load_idx_before_reset", key_idx, 3);
    puc_rst_n = 1'b0;
    #1;
    chk_reset_vals();
    exp_q.delete();
    tick();
    tick();
    puc_rst_n = 1'b1;
    tick();
    chk("post_reset_ready", cmd_ready, 1);
    run_cmd(mkv(2'b00, 0, 1, 4, rkey(), 13, 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/omsp_spm_cmd_sequencer.md
# omsp_spm_cmd_sequencer

Sequences Sancus protected-module (SM) commands into the SM control array. Accepts one command at a time from the execution unit: enable, disable or verify. Drives the single-cycle `update_spm`/`enable_spm`/`disable_spm`/`verify_spm`/`cancel_spm` strobes, checks the array's `violation` result, and cancels the allocation on failure. For enable, it then streams the derived module key from the crypto unit into the new SM, 16 bits per cycle, over `write_key`/`key_in`/`key_idx`.

## Interface
- KEY_WORDS, 8: number of 16-bit key words per key (`SECURITY`/16).
- KEY_IDX_SIZE, 3: width of `key_idx`; must satisfy 2^KEY_IDX_SIZE >= KEY_WORDS.
- mclk  in  1  core clock.
- puc_rst_n  in  1  one clock; reset is asynchronous and active-low.
- cmd_valid  in  1  command request.
- cmd_op  in  2  command: 00 enable, 01 disable, 10 verify, 11 reserved.
- cmd_ready  out  1  sequencer idle; a command is accepted when `cmd_valid & cmd_ready`.
- key_valid  in  1  crypto unit presents the derived key.
- key_data  in  KEY_WORDS*16  key; word n is `key_data[n*16+:16]`.
- key_ready  out  1  sequencer waiting for the key.
- violation  in  1  SM array violation, combinational from the strobes.
- update_spm, enable_spm, disable_spm, verify_spm, cancel_spm  out  1 each  registered command strobes.
- write_key  out  1  key word write strobe.
- key_in  out  16  key word.
- key_idx  out  KEY_IDX_SIZE  key word index.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle success pulse.
- error  out  1  one-cycle failure pulse.

## Operation
- States: IDLE, ISSUE, CHECK, WAIT_KEY, LOAD, CANCEL, FIN.
- IDLE
  - `cmd_ready`=1.
  - On accept, latch `cmd_op`.
  - If op=11: pulse `error` next cycle and stay in IDLE.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle)
  - `update_spm`=1 plus exactly one of `enable_spm`/`disable_spm`/`verify_spm`.
  - Go to CHECK.
- CHECK (1 cycle)
  - All strobes are 0. `violation` is sampled, reflecting the state registered during ISSUE.
  - Enable: violation -> CANCEL; otherwise -> WAIT_KEY.
  - Disable/verify: violation -> FIN with error; otherwise -> FIN with done.
- CANCEL (1 cycle)
  - `update_spm`=1, `cancel_spm`=1; the array reclaims the ID.
  - Go to FIN with error.
- WAIT_KEY
  - `key_ready`=1.
  - On `key_valid`, capture `key_data` into an internal register and go to LOAD. The crypto unit may change `key_data` afterwards.
- LOAD (KEY_WORDS cycles)
  - `write_key`=1, `key_idx`=n, `key_in`=word n, for n=0..KEY_WORDS-1.
  - After the last word, go to FIN with done.
- FIN (1 cycle)
  - Exactly one of `done`/`error` is 1.
  - Go to IDLE.
- At most one command strobe group is active per cycle.
- `cancel_spm` never asserts outside CANCEL.
- A command arriving while busy is held off by `cmd_ready`=0; it is not lost.
- Reset mid-operation: all state clears immediately. No cancel is issued, because the SM array resets with the same reset.

## Timing
- Reset values: `cmd_ready`=1, `key_ready`=0, `busy`=0, `done`=0, `error`=0, all strobes 0, `key_in`=0, `key_idx`=0.
- All outputs except `cmd_ready`, `key_ready` and `busy` are registered. Those three decode directly from the state register.
- Accept at cycle 0:
  - ISSUE strobes at cycle 1.
  - CHECK at cycle 2.
  - Disable/verify: done/error at cycle 3.
  - Enable with violation: cancel at cycle 3, error at cycle 4.
- Enable without violation: WAIT_KEY from cycle 3. If the key is accepted at cycle k, `write_key` is high for cycles k+1..k+KEY_WORDS and `done` is at cycle k+KEY_WORDS+1.
- Back-to-back commands: the next command is accepted at the earliest in the cycle after FIN.
- The `key_idx` counter saturates. It never wraps past KEY_WORDS-1.

## Configuration
- `SPM_KEY_TIMEOUT_EN`
  - Defined: an 8-bit counter runs in WAIT_KEY. After 255 cycles without `key_valid`, go to CANCEL; an error pulse follows. A `key_valid` in cycle 255 is ignored and cancel wins.
  - Undefined: WAIT_KEY waits indefinitely and the counter is not instantiated.

## Test plan
- Enable, no violation, key=0x0001_0002_..._0008 (word 0=0x0008) presented at cycle 5 -> `update_spm`+`enable_spm` at cycle 1; `write_key` high at cycles 6..13 with idx 0..7 and `key_in` 0x0008..0x0001; `done` at cycle 14.
- Enable with `violation` forced high in CHECK -> `update_spm`+`cancel_spm` at cycle 3, `error` at cycle 4, no `write_key`.
- Disable, then verify with violation -> disable: `done` at cycle 3; verify: `error` at cycle 3; `cmd_ready` low for cycles 1-3 of each command.
- op=11 -> `error` at cycle 1, no strobes, `cmd_ready` stays 1.
- Reset asserted during LOAD at word 3 -> all outputs take their reset values asynchronously; after release, `cmd_ready`=1 and the next enable starts at idx 0.
- With `SPM_KEY_TIMEOUT_EN`, no key presented -> cancel 255 cycles after entering WAIT_KEY, then `error`.
